pll_reconfig_ctrl: RTL and testbench

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

---
 rtl/pll_ctrl_pkg.sv | 33 +++
 rtl/pll_lock_filter.sv | 55 +++++
 rtl/pll_reconfig_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reconfiguration controller:
// FSM state encoding, divider/duty reset defaults and counter widths.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_PWD       = 3'd0,
        ST_RST       = 3'd1,
        ST_WAIT_LOCK = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_ERROR     = 3'd4
    } pll_state_e;

    localparam int unsigned DATA_W  = 10;
    localparam int unsigned TMO_W   = 16;
    localparam int unsigned PHASE_W = 16;
    localparam int unsigned RETRY_W = 2;

    localparam logic [DATA_W-1:0] ODIV_DEF = 10'd100;
    localparam logic [DATA_W-1:0] DUTY_DEF = 10'd100;

    // Increment that holds at lim instead of wrapping.
    function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v,
                                                 input logic [TMO_W-1:0] lim);
        logic [TMO_W-1:0] r;
        if (v >= lim) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// Two-flop synchronizer for the raw PLL lock plus a stability counter that
// reports lock_ok once LOCK_STABLE consecutive high samples have been seen.
module pll_lock_filter
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_STABLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_lock,
    input  logic count_en,
    output logic lock_sync,
    output logic lock_ok
);

    localparam int unsigned      STAB_W   = $clog2(LOCK_STABLE + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(LOCK_STABLE);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [STAB_W-1:0] stab_q,  stab_d;

    // Synchronizer and stability counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            stab_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            stab_q  <= stab_d;
        end
    end

    // Counter runs only while the controller waits for lock; any low sample restarts it.
    always_comb begin
        sync1_d = pll_lock;
        sync2_d = sync1_q;
        stab_d  = stab_q;
        if (!count_en) begin
            stab_d = '0;
        end else if (!sync2_q) begin
            stab_d = '0;
        end else if (stab_q == STAB_MAX) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + STAB_W'(1);
        end
    end

    assign lock_sync = sync2_q;
    assign lock_ok   = (stab_q == STAB_MAX);

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL power-up / lock-acquire / reconfiguration sequencer with bounded
// retries, lock-loss relock and a terminal error state.
module pll_reconfig_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned PWD_CYCLES   = 10,
    parameter int unsigned RST_CYCLES   = 10,
    parameter int unsigned LOCK_STABLE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [DATA_W-1:0]  cfg_odiv0,
    input  logic [DATA_W-1:0]  cfg_odiv1,
    input  logic [DATA_W-1:0]  cfg_duty0,
    input  logic [DATA_W-1:0]  cfg_duty1,
    output logic               pll_pwd,
    output logic               pll_rst,
    output logic [DATA_W-1:0]  dyn_odiv0,
    output logic [DATA_W-1:0]  dyn_odiv1,
    output logic [DATA_W-1:0]  dyn_duty0,
    output logic [DATA_W-1:0]  dyn_duty1,
    output logic               clk_en,
    output logic               locked,
    output logic               err,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam logic [PHASE_W-1:0] PWD_LAST   = PHASE_W'(PWD_CYCLES - 1);
    localparam logic [PHASE_W-1:0] RST_LAST   = PHASE_W'(RST_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LIMIT  = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]   TMO_SAT    = TMO_W'(LOCK_TIMEOUT);
    localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);

    pll_state_e         state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [DATA_W-1:0]  odiv0_q, odiv0_d, odiv1_q, odiv1_d;
    logic [DATA_W-1:0]  duty0_q, duty0_d, duty1_q, duty1_d;
    logic               pwd_q, pwd_d, prst_q, prst_d;
    logic               locked_q, locked_d, ready_q, ready_d, err_q, err_d;
    logic               lock_sync_s, lock_ok_s, cfg_fire_s;

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk       (clk),
        .rst       (rst),
        .pll_lock  (pll_lock),
        .count_en  (state_q == ST_WAIT_LOCK),
        .lock_sync (lock_sync_s),
        .lock_ok   (lock_ok_s)
    );

    assign cfg_fire_s = cfg_valid & ready_q;

    // State, counters, captured configuration and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_PWD;
            phase_q  <= '0;
            tmo_q    <= '0;
            retry_q  <= '0;
            odiv0_q  <= ODIV_DEF;
            odiv1_q  <= ODIV_DEF;
            duty0_q  <= DUTY_DEF;
            duty1_q  <= DUTY_DEF;
            pwd_q    <= 1'b1;
            prst_q   <= 1'b1;
            locked_q <= 1'b0;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tmo_q    <= tmo_d;
            retry_q  <= retry_d;
            odiv0_q  <= odiv0_d;
            odiv1_q  <= odiv1_d;
            duty0_q  <= duty0_d;
            duty1_q  <= duty1_d;
            pwd_q    <= pwd_d;
            prst_q   <= prst_d;
            locked_q <= locked_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
        end
    end

    // Sequencer next-state logic; outputs are decoded from the next state so they
    // change on the same edge as the state register.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        odiv0_d = odiv0_q;
        odiv1_d = odiv1_q;
        duty0_d = duty0_q;
        duty1_d = duty1_q;
        case (state_q)
            ST_PWD: begin
                if (phase_q == PWD_LAST) begin
                    state_d = ST_RST;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_RST: begin
                if (phase_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    phase_d = '0;
                    tmo_d   = '0;
                end else begin
                    phase_d = phase_q + 16'd1;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_ok_s) begin
                    state_d = ST_LOCKED;
                end else if (tmo_q >= TMO_LIMIT) begin
                    if (retry_q >= RETRY_LAST) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_RST;
                        phase_d = '0;
                        retry_d = retry_q + 2'd1;
                    end
                end else begin
                    tmo_d = sat_inc(tmo_q, TMO_SAT);
                end
            end
            ST_LOCKED: begin
                retry_d = '0;
                // A cfg handshake takes priority and also covers a coincident lock loss.
                if (cfg_fire_s) begin
                    odiv0_d = cfg_odiv0;
                    odiv1_d = cfg_odiv1;
                    duty0_d = cfg_duty0;
                    duty1_d = cfg_duty1;
                    state_d = ST_RST;
                    phase_d = '0;
                end else if (!lock_sync_s) begin
                    state_d = ST_RST;
                    phase_d = '0;
                end else begin
                    state_d = ST_LOCKED;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_PWD;
                phase_d = '0;
            end
        endcase

        pwd_d    = (state_d == ST_PWD) || (state_d == ST_ERROR);
        prst_d   = (state_d == ST_PWD) || (state_d == ST_RST) || (state_d == ST_ERROR);
        locked_d = (state_d == ST_LOCKED);
        ready_d  = (state_d == ST_LOCKED);
        err_d    = (state_d == ST_ERROR);
    end

    assign pll_pwd   = pwd_q;
    assign pll_rst   = prst_q;
    assign dyn_odiv0 = odiv0_q;
    assign dyn_odiv1 = odiv1_q;
    assign dyn_duty0 = duty0_q;
    assign dyn_duty1 = duty1_q;
    assign clk_en    = locked_q;
    assign locked    = locked_q;
    assign cfg_ready = ready_q;
    assign err       = err_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl: a vector table for bring-up and
// reconfiguration, plus hand sequences for glitch, collision, timeout and reset.
module tb_pll_reconfig_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [9:0] cfg_odiv0 = 10'd100, cfg_odiv1 = 10'd150;
    logic [9:0] cfg_duty0 = 10'd100, cfg_duty1 = 10'd50;
    logic       pll_pwd, pll_rst, clk_en, locked, err;
    logic [9:0] dyn_odiv0, dyn_odiv1, dyn_duty0, dyn_duty1;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;
    int pwd_rise = 0;
    int rst_rise = 0;
    logic prev_pwd = 1'b1;
    logic prev_rst = 1'b1;

    localparam int SIG_PWD = 0, SIG_RST = 1, SIG_LOCKED = 2, SIG_ERR = 3;

    pll_reconfig_ctrl #(
        .PWD_CYCLES (10), .RST_CYCLES (10), .LOCK_STABLE (16),
        .LOCK_TIMEOUT (200), .MAX_RETRY (3)
    ) dut (
        .clk (clk), .rst (rst), .pll_lock (pll_lock),
        .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
        .cfg_odiv0 (cfg_odiv0), .cfg_odiv1 (cfg_odiv1),
        .cfg_duty0 (cfg_duty0), .cfg_duty1 (cfg_duty1),
        .pll_pwd (pll_pwd), .pll_rst (pll_rst),
        .dyn_odiv0 (dyn_odiv0), .dyn_odiv1 (dyn_odiv1),
        .dyn_duty0 (dyn_duty0), .dyn_duty1 (dyn_duty1),
        .clk_en (clk_en), .locked (locked), .err (err), .retry_cnt (retry_cnt)
    );

    always #5 clk = ~clk;

    // Count rising edges of pll_pwd / pll_rst to detect extra pulses.
    always @(negedge clk) begin
        if (pll_pwd === 1'b1 && prev_pwd !== 1'b1) pwd_rise = pwd_rise + 1;
        if (pll_rst === 1'b1 && prev_rst !== 1'b1) rst_rise = rst_rise + 1;
        prev_pwd = pll_pwd;
        prev_rst = pll_rst;
    end

    typedef struct {
        int         cyc;
        logic       rst_i, lock_i, valid_i;
        logic [9:0] odiv0_i, duty0_i;
        logic       e_pwd, e_prst, e_locked, e_clk_en, e_ready, e_err;
        logic [1:0] e_retry;
        logic [9:0] e_odiv0, e_duty0;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic get_sig(input int sel);
        logic v;
        case (sel)
            SIG_PWD:    v = pll_pwd;
            SIG_RST:    v = pll_rst;
            SIG_LOCKED: v = locked;
            SIG_ERR:    v = err;
            default:    v = 1'bx;
        endcase
        return v;
    endfunction

    task automatic count_until(input int sel, input logic val, input int budget, output int n);
        n = 0;
        while (get_sig(sel) !== val && n < budget) begin
            step();
            n = n + 1;
        end
    endtask

    task automatic pulse_len(input int sel, input int budget, output int n);
        n = 0;
        while (get_sig(sel) === 1'b1 && n < budget) begin
            n = n + 1;
            step();
        end
    endtask

    initial begin
        int n, pwd_base, rst_base, r300, r500;
        logic saw_lock;

        vecs[0]  = '{3,   1'b1, 1'b0, 1'b0, 10'd100, 10'd100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100, 10'd100};
        vecs[1]  = '{9,   1'b0, 1'b0, 1'b0, 10'd100, 10'd100, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100, 10'd100};
        vecs[2]  = '{1,   1'b0, 1'b0, 1'b0, 10'd100, 10'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100, 10'd100};
        vecs[3]  = '{9,   1'b0, 1'b0, 1'b0, 10'd100, 10'd100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100, 10'd100};
        vecs[4]  = '{1,   1'b0, 1'b0, 1'b0, 10'd100, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100, 10'd100};
        vecs[5]  = '{100, 1'b0, 1'b0, 1'b0, 10'd100, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100, 10'd100};
        vecs[6]  = '{18,  1'b0, 1'b1, 1'b0, 10'd100, 10'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd100, 10'd100};
        vecs[7]  = '{1,   1'b0, 1'b1, 1'b0, 10'd100, 10'd100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 10'd100, 10'd100};
        vecs[8]  = '{1,   1'b0, 1'b1, 1'b1, 10'd200, 10'd200, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd200, 10'd200};
        vecs[9]  = '{9,   1'b0, 1'b1, 1'b0, 10'd300, 10'd300, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd200, 10'd200};
        vecs[10] = '{1,   1'b0, 1'b1, 1'b0, 10'd300, 10'd300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd200, 10'd200};
        vecs[11] = '{16,  1'b0, 1'b1, 1'b0, 10'd300, 10'd300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 10'd200, 10'd200};
        vecs[12] = '{1,   1'b0, 1'b1, 1'b0, 10'd300, 10'd300, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 10'd200, 10'd200};

        // Reset, bring-up, first lock and a reconfiguration.
        for (int i = 0; i < 13; i++) begin
            rst       = vecs[i].rst_i;
            pll_lock  = vecs[i].lock_i;
            cfg_valid = vecs[i].valid_i;
            cfg_odiv0 = vecs[i].odiv0_i;
            cfg_duty0 = vecs[i].duty0_i;
            repeat (vecs[i].cyc) step();
            check($sformatf("v%0d_pwd", i),    32'(pll_pwd),   32'(vecs[i].e_pwd));
            check($sformatf("v%0d_prst", i),   32'(pll_rst),   32'(vecs[i].e_prst));
            check($sformatf("v%0d_locked", i), 32'(locked),    32'(vecs[i].e_locked));
            check($sformatf("v%0d_clk_en", i), 32'(clk_en),    32'(vecs[i].e_clk_en));
            check($sformatf("v%0d_ready", i),  32'(cfg_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d_err", i),    32'(err),       32'(vecs[i].e_err));
            check($sformatf("v%0d_retry", i),  32'(retry_cnt), 32'(vecs[i].e_retry));
            check($sformatf("v%0d_odiv0", i),  32'(dyn_odiv0), 32'(vecs[i].e_odiv0));
            check($sformatf("v%0d_duty0", i),  32'(dyn_duty0), 32'(vecs[i].e_duty0));
        end
        check("cfg_odiv1_captured", 32'(dyn_odiv1), 32'd150);
        check("cfg_duty1_captured", 32'(dyn_duty1), 32'd50);

        // One-cycle lock glitch while locked: relock through RST only.
        pwd_base = pwd_rise; rst_base = rst_rise;
        pll_lock = 1'b0; step();
        pll_lock = 1'b1; step();
        check("glitch_locked_hold", 32'(locked), 32'd1);
        step();
        check("glitch_locked_drop", 32'(locked), 32'd0);
        check("glitch_clk_en_drop", 32'(clk_en), 32'd0);
        check("glitch_pwd_low", 32'(pll_pwd), 32'd0);
        pulse_len(SIG_RST, 50, n);
        check("glitch_rst_pulse", 32'(n), 32'd10);
        count_until(SIG_LOCKED, 1'b1, 100, n);
        check("glitch_relock_cycles", 32'(n), 32'd17);
        check("glitch_no_pwd", 32'(pwd_rise - pwd_base), 32'd0);
        check("glitch_one_rst", 32'(rst_rise - rst_base), 32'd1);

        // cfg handshake in the same cycle the synchronized lock goes low.
        pwd_base = pwd_rise; rst_base = rst_rise;
        pll_lock = 1'b0; step();
        pll_lock = 1'b1; step();
        cfg_valid = 1'b1; cfg_odiv1 = 10'd333; step();
        cfg_valid = 1'b0;
        check("coll_odiv1", 32'(dyn_odiv1), 32'd333);
        check("coll_locked_drop", 32'(locked), 32'd0);
        check("coll_rst_high", 32'(pll_rst), 32'd1);
        pulse_len(SIG_RST, 50, n);
        check("coll_rst_pulse", 32'(n), 32'd10);
        count_until(SIG_LOCKED, 1'b1, 100, n);
        check("coll_relock_cycles", 32'(n), 32'd17);
        check("coll_one_rst", 32'(rst_rise - rst_base), 32'd1);
        check("coll_no_pwd", 32'(pwd_rise - pwd_base), 32'd0);

        // Toggling lock never qualifies; three timeouts lead to ERROR.
        rst = 1'b1; step(); step();
        rst = 1'b0;
        n = 0; saw_lock = 1'b0; r300 = -1; r500 = -1;
        while (err !== 1'b1 && n < 1000) begin
            pll_lock = ((n / 8) % 2) == 1;
            step();
            n = n + 1;
            if (locked === 1'b1) saw_lock = 1'b1;
            if (n == 300) r300 = int'(retry_cnt);
            if (n == 500) r500 = int'(retry_cnt);
        end
        check("tmo_err_cycle", 32'(n), 32'd640);
        check("tmo_never_locked", 32'(saw_lock), 32'd0);
        check("tmo_retry_1", 32'(r300), 32'd1);
        check("tmo_retry_2", 32'(r500), 32'd2);
        check("err_retry_cnt", 32'(retry_cnt), 32'd2);
        check("err_pwd", 32'(pll_pwd), 32'd1);
        check("err_prst", 32'(pll_rst), 32'd1);
        check("err_clk_en", 32'(clk_en), 32'd0);

        // ERROR ignores lock and cfg requests.
        pll_lock = 1'b1; cfg_valid = 1'b1; cfg_odiv0 = 10'd555;
        repeat (40) step();
        check("err_sticky", 32'(err), 32'd1);
        check("err_no_lock", 32'(locked), 32'd0);
        check("err_no_ready", 32'(cfg_ready), 32'd0);
        check("err_cfg_ignored", 32'(dyn_odiv0), 32'd100);
        cfg_valid = 1'b0; pll_lock = 1'b0;

        // Reset out of ERROR.
        rst = 1'b1; step();
        check("rst_err_err", 32'(err), 32'd0);
        check("rst_err_retry", 32'(retry_cnt), 32'd0);
        check("rst_err_pwd", 32'(pll_pwd), 32'd1);
        check("rst_err_prst", 32'(pll_rst), 32'd1);
        check("rst_err_ready", 32'(cfg_ready), 32'd0);
        rst = 1'b0;
        count_until(SIG_PWD, 1'b0, 50, n);
        check("rst_err_pwd_len", 32'(n), 32'd10);
        count_until(SIG_RST, 1'b0, 50, n);
        check("rst_err_rst_len", 32'(n), 32'd10);

        // Reset in the middle of WAIT_LOCK restarts at PWD.
        repeat (50) step();
        check("wait_pwd_low", 32'(pll_pwd), 32'd0);
        rst = 1'b1; step();
        check("rst_wait_pwd", 32'(pll_pwd), 32'd1);
        check("rst_wait_prst", 32'(pll_rst), 32'd1);
        check("rst_wait_locked", 32'(locked), 32'd0);
        check("rst_wait_odiv1", 32'(dyn_odiv1), 32'd100);
        rst = 1'b0;
        count_until(SIG_PWD, 1'b0, 50, n);
        check("rst_wait_pwd_len", 32'(n), 32'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
